// File: rtl/risc32_mem_wb.sv
// MEM/WB pipeline register and writeback stage: big-endian load alignment, regfile write port,
// retired-instruction counter and optional HI/LO pair (enabled by defining RISC32_HILO_EN).
module risc32_mem_wb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [DW-1:0] mem_wdata_i,
  input  logic          mem_load_i,
  input  logic [2:0]    mem_load_type_i,
  input  logic [1:0]    mem_addr_lo_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          hilo_we_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_waddr_o,
  output logic [DW-1:0] wb_wdata_o,
  output logic          load_misalign_o,
  output logic [CW-1:0] instret_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [DW-1:0] load_data_s;
  logic          misalign_s;
  logic [DW-1:0] wdata_s;
  logic          we_s;

  // Byte/halfword selection and misalignment detection for loads.
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    load_data_s = mem_rdata_i;
    misalign_s  = 1'b0;
    case (mem_addr_lo_i)
      2'd0:    byte_s = mem_rdata_i[DW-1 -: 8];
      2'd1:    byte_s = mem_rdata_i[DW-9 -: 8];
      2'd2:    byte_s = mem_rdata_i[15:8];
      2'd3:    byte_s = mem_rdata_i[7:0];
      default: byte_s = 8'h00;
    endcase
    if (mem_addr_lo_i[1]) begin
      half_s = mem_rdata_i[15:0];
    end else begin
      half_s = mem_rdata_i[DW-1 -: 16];
    end
    case (mem_load_type_i)
      3'b000: load_data_s = {{(DW-8){byte_s[7]}}, byte_s};
      3'b001: load_data_s = {{(DW-8){1'b0}}, byte_s};
      3'b010: begin
        load_data_s = {{(DW-16){half_s[15]}}, half_s};
        misalign_s  = mem_addr_lo_i[0];
      end
      3'b011: begin
        load_data_s = {{(DW-16){1'b0}}, half_s};
        misalign_s  = mem_addr_lo_i[0];
      end
      default: begin
        load_data_s = mem_rdata_i;
        misalign_s  = (mem_addr_lo_i != 2'b00);
      end
    endcase
  end

  // Final write data and effective write enable for the incoming instruction.
  always_comb begin
    wdata_s = mem_wdata_i;
    we_s    = 1'b0;
    if (mem_load_i) begin
      wdata_s = load_data_s;
    end else begin
      wdata_s = mem_wdata_i;
    end
    if (mem_valid_i && mem_we_i && (mem_waddr_i != '0) && !(mem_load_i && misalign_s)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // WB pipeline register and retire counter; flush beats stall, invalid slots become bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_o         <= 1'b0;
      wb_waddr_o      <= '0;
      wb_wdata_o      <= '0;
      load_misalign_o <= 1'b0;
      instret_o       <= '0;
    end else if (flush_i || (!stall_i && !mem_valid_i)) begin
      wb_we_o         <= 1'b0;
      wb_waddr_o      <= '0;
      wb_wdata_o      <= '0;
      load_misalign_o <= 1'b0;
    end else if (!stall_i) begin
      wb_we_o         <= we_s;
      wb_waddr_o      <= mem_waddr_i;
      wb_wdata_o      <= wdata_s;
      load_misalign_o <= mem_load_i & misalign_s;
      instret_o       <= instret_o + {{(CW-1){1'b0}}, 1'b1};
    end
  end

`ifdef RISC32_HILO_EN
  logic          hilo_we_r;
  logic [DW-1:0] hi_wb_r;
  logic [DW-1:0] lo_wb_r;
  logic [DW-1:0] hi_r;
  logic [DW-1:0] lo_r;

  // HI/LO values travelling with the instruction through the WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_we_r <= 1'b0;
      hi_wb_r   <= '0;
      lo_wb_r   <= '0;
    end else if (flush_i || (!stall_i && !mem_valid_i)) begin
      hilo_we_r <= 1'b0;
      hi_wb_r   <= '0;
      lo_wb_r   <= '0;
    end else if (!stall_i) begin
      hilo_we_r <= hilo_we_i;
      hi_wb_r   <= hi_i;
      lo_wb_r   <= lo_i;
    end
  end

  // Architectural HI/LO commit; rewriting the same held value during a stall is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (hilo_we_r) begin
      hi_r <= hi_wb_r;
      lo_r <= lo_wb_r;
    end
  end

  assign hi_o = hilo_we_r ? hi_wb_r : hi_r;
  assign lo_o = hilo_we_r ? lo_wb_r : lo_r;
`else
  logic unused_hilo;
  assign unused_hilo = ^{hilo_we_i, hi_i, lo_i};
  assign hi_o = '0;
  assign lo_o = '0;
`endif

endmodule

// File: tb/tb_risc32_mem_wb.sv
// Directed table-driven bench for risc32_mem_wb plus stall/flush, HI/LO and async-reset sequences.
module tb_risc32_mem_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_we_i, mem_load_i, stall_i, flush_i, hilo_we_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i, mem_rdata_i, hi_i, lo_i;
  logic [2:0]  mem_load_type_i;
  logic [1:0]  mem_addr_lo_i;
  logic        wb_we_o, load_misalign_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o, instret_o, hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  risc32_mem_wb dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i),
    .mem_wdata_i(mem_wdata_i), .mem_load_i(mem_load_i), .mem_load_type_i(mem_load_type_i),
    .mem_addr_lo_i(mem_addr_lo_i), .mem_rdata_i(mem_rdata_i), .stall_i(stall_i),
    .flush_i(flush_i), .hilo_we_i(hilo_we_i), .hi_i(hi_i), .lo_i(lo_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .load_misalign_o(load_misalign_o), .instret_o(instret_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        load;
    logic [2:0]  ltype;
    logic [1:0]  alo;
    logic [31:0] rdata;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        chk_data;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string nm, input logic chk_data, input logic e_we,
                       input logic [4:0] e_waddr, input logic [31:0] e_wdata, input logic e_mis);
    logic [134:0] act;
    logic [134:0] exp;
    act = {wb_we_o, chk_data ? wb_waddr_o : 5'd0, chk_data ? wb_wdata_o : 32'd0,
           load_misalign_o, instret_o, hi_o, lo_o};
    exp = {e_we, chk_data ? e_waddr : 5'd0, chk_data ? e_wdata : 32'd0,
           e_mis, exp_instret, exp_hi, exp_lo};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ld, input logic [2:0] lt, input logic [1:0] alo,
                        input logic [31:0] rd);
    mem_valid_i = v; mem_we_i = we; mem_waddr_i = wa; mem_wdata_i = wd;
    mem_load_i = ld; mem_load_type_i = lt; mem_addr_lo_i = alo; mem_rdata_i = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    r = 32'h80FF_7F01;
    //            valid we   wa     wdata          ld   type    alo    rdata  | we   wa     wdata          mis  chk
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b000, 2'd0, 32'd0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b000, 2'd0, r,     1'b1, 5'd3, 32'hFFFF_FF80, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b001, 2'd0, r,     1'b1, 5'd3, 32'h0000_0080, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b010, 2'd2, r,     1'b1, 5'd3, 32'h0000_7F01, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b011, 2'd0, r,     1'b1, 5'd3, 32'h0000_80FF, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b100, 2'd0, r,     1'b1, 5'd3, 32'h80FF_7F01, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1, 3'b000, 2'd1, r,     1'b1, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1, 3'b001, 2'd3, r,     1'b1, 5'd4, 32'h0000_0001, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1, 3'b010, 2'd0, r,     1'b1, 5'd4, 32'hFFFF_80FF, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b1, 3'b111, 2'd0, r,     1'b1, 5'd8, 32'h80FF_7F01, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b010, 2'd1, r,     1'b0, 5'd0, 32'd0,         1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b100, 2'd2, r,     1'b0, 5'd0, 32'd0,         1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 3'b011, 2'd3, r,     1'b0, 5'd0, 32'd0,         1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 5'd0, 32'h0000_0055, 1'b0, 3'b000, 2'd0, r,     1'b0, 5'd0, 32'h0000_0055, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 5'd6, 32'h0000_0077, 1'b0, 3'b000, 2'd0, r,     1'b0, 5'd0, 32'd0,         1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 5'd7, 32'h0000_0099, 1'b0, 3'b000, 2'd0, r,     1'b0, 5'd7, 32'h0000_0099, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 5'd31, 32'h0,        1'b1, 3'b001, 2'd2, r,     1'b1, 5'd31, 32'h0000_007F, 1'b0, 1'b1};

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; hilo_we_i = 1'b0; hi_i = 32'd0; lo_i = 32'd0;
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'b000, 2'd0, 32'd0);
    #2;
    check("reset", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(); step();
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].valid, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
             vecs[i].load, vecs[i].ltype, vecs[i].alo, vecs[i].rdata);
      step();
      if (vecs[i].valid) exp_instret = exp_instret + 32'd1;
      check($sformatf("vec%0d", i), vecs[i].chk_data, vecs[i].exp_we, vecs[i].exp_waddr,
            vecs[i].exp_wdata, vecs[i].exp_mis);
    end

    // stall holds for three cycles, then flush overrides stall
    set_in(1'b1, 1'b1, 5'd9, 32'hAAAA_5555, 1'b0, 3'b000, 2'd0, 32'd0);
    step();
    exp_instret = exp_instret + 32'd1;
    check("pre_stall", 1'b1, 1'b1, 5'd9, 32'hAAAA_5555, 1'b0);
    set_in(1'b1, 1'b1, 5'd10, 32'h0000_1111, 1'b0, 3'b000, 2'd0, 32'd0);
    stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d", c), 1'b1, 1'b1, 5'd9, 32'hAAAA_5555, 1'b0);
    end
    flush_i = 1'b1;
    step();
    check("flush_over_stall", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    flush_i = 1'b0; stall_i = 1'b0;
    step();
    exp_instret = exp_instret + 32'd1;
    check("stall_release", 1'b1, 1'b1, 5'd10, 32'h0000_1111, 1'b0);

    // HI/LO write: bypass in WB cycle, then committed value, flush squashes a later write
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 3'b000, 2'd0, 32'd0);
    hilo_we_i = 1'b1; hi_i = 32'h0000_000A; lo_i = 32'h0000_000B;
    step();
    exp_instret = exp_instret + 32'd1;
`ifdef RISC32_HILO_EN
    exp_hi = 32'h0000_000A; exp_lo = 32'h0000_000B;
`endif
    check("hilo_bypass", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    hilo_we_i = 1'b0; hi_i = 32'h0000_000C; lo_i = 32'h0000_000D;
    step();
    exp_instret = exp_instret + 32'd1;
    check("hilo_commit", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    hilo_we_i = 1'b1; hi_i = 32'h0000_000E; lo_i = 32'h0000_000F; flush_i = 1'b1;
    step();
    check("hilo_flush", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    flush_i = 1'b0; hilo_we_i = 1'b0;

    // asynchronous reset mid-stream
    set_in(1'b1, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0, 3'b000, 2'd0, 32'd0);
    step();
    exp_instret = exp_instret + 32'd1;
    check("pre_rst", 1'b1, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_instret = 32'd0; exp_hi = 32'd0; exp_lo = 32'd0;
    check("async_rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    rst = 1'b0;
    step();
    exp_instret = 32'd1;
    check("post_rst", 1'b1, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
